branch_resolve: RTL

- Consumer end of the branch-compare interface. Takes the 2-bit compare flag and the branch type from the ID/EX stage and decides taken or not-taken. Checks that decision against the fetch-stage prediction.
- On a mispredict it raises a registered redirect to the fetch unit using a valid/ready handshake. It then flushes wrong-path slots for a fixed number of cycles.
- Sits between the branch comparator and the IF/PC logic. Also keeps saturating branch statistics.

---
 rtl/branch_resolve_pkg.sv | 24 ++
 rtl/branch_resolve_decode.sv | 35 +++
 rtl/branch_resolve.sv | 120 ++++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the branch-compare interface: comparator flags,
// branch type codes and resolve FSM states.
package branch_resolve_pkg;

  localparam logic [1:0] BRANCH_DEFAULT = 2'b00;
  localparam logic [1:0] BRANCH_EQUAL   = 2'b01;
  localparam logic [1:0] BRANCH_LT      = 2'b10;
  localparam logic [1:0] BRANCH_GT      = 2'b11;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLTZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLEZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;
  localparam logic [2:0] BR_J    = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/branch_resolve_decode.sv
// Combinational taken/not-taken decision from branch type and comparator flag.
// err flags a conditional branch with no comparator result, or an unknown type.
module br_taken_decode
  import branch_resolve_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic [1:0] cmp_flag,
  output logic       taken,
  output logic       err
);

  logic cond_type;

  always_comb begin
    taken     = 1'b0;
    cond_type = 1'b1;
    case (br_type)
      BR_BEQ:  taken = (cmp_flag == BRANCH_EQUAL);
      BR_BNE:  taken = (cmp_flag == BRANCH_LT) || (cmp_flag == BRANCH_GT);
      BR_BLTZ: taken = (cmp_flag == BRANCH_LT);
      BR_BGTZ: taken = (cmp_flag == BRANCH_GT);
      BR_BLEZ: taken = (cmp_flag == BRANCH_EQUAL) || (cmp_flag == BRANCH_LT);
      BR_BGEZ: taken = (cmp_flag == BRANCH_EQUAL) || (cmp_flag == BRANCH_GT);
      BR_J: begin
        taken     = 1'b1;
        cond_type = 1'b0;
      end
      default: taken = 1'b0;
    endcase
  end

  // An undefined type code is reported the same way as a missing compare result.
  assign err = (br_type > BR_J) || (cond_type && (cmp_flag == BRANCH_DEFAULT));

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches against the fetch prediction, issues a redirect on
// mispredict over a valid/ready handshake, then flushes wrong-path slots.
//
// state    | meaning
// IDLE     | resolving branches, no redirect outstanding
// REDIRECT | redirect_pc offered to fetch, ID/EX held, IF/ID squashed
// FLUSH    | redirect accepted, squashing remaining wrong-path slots
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic [1:0]        cmp_flag,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] fall_pc,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              stall_o,
  output logic              flush_o,
  output logic              cmp_err,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] flush_cnt;
  logic       taken, dec_err;
  logic       resolve, mispredict, handshake;

  br_taken_decode u_decode (
    .br_type  (br_type),
    .cmp_flag (cmp_flag),
    .taken    (taken),
    .err      (dec_err)
  );

  // Branches are only acted on in IDLE; anything arriving later is wrong-path.
  assign resolve    = br_valid && (state == IDLE);
  assign mispredict = resolve && (taken != pred_taken);
  assign handshake  = (state == REDIRECT) && redirect_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mispredict) state_nxt = REDIRECT;
      REDIRECT: if (handshake) state_nxt = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
      FLUSH:    if (flush_cnt == 4'd0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = 1'b0;
    stall_o        = 1'b0;
    flush_o        = 1'b0;
    case (state)
      REDIRECT: begin
        redirect_valid = 1'b1;
        stall_o        = 1'b1;
        flush_o        = 1'b1;
      end
      FLUSH:   flush_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 4'd0;
    end else if (handshake) begin
      flush_cnt <= FLUSH_INIT;
    end else if (state == FLUSH && flush_cnt != 4'd0) begin
      flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // Target is captured only on entry to REDIRECT so it stays stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc <= '0;
    end else if (mispredict) begin
      redirect_pc <= taken ? br_target : fall_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_err     <= 1'b0;
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      cmp_err <= resolve && dec_err;
      if (resolve && taken && taken_cnt != '1) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
      if (mispredict && mispred_cnt != '1) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end

endmodule
